// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed hex driver for N common-anode seven-segment digits on a shared
// active-low segment bus, with frame-aligned double buffering of display data.
module sevenseg_mux_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_en,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [7:0]            segments,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q;

  logic [4*N_DIGITS-1:0] pend_value_q, pend_value_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                  pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [4*N_DIGITS-1:0] act_value_q, act_value_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   act_en_q, act_en_d;
  logic                  act_lz_q, act_lz_d;

  logic [7:0]            segments_q, segments_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;

  logic                  tick, wrap;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   supp, lit, sel;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_lit;

  // Active-low glyphs {a,b,c,d,e,f,g,dp}, dp bit left off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] apply_dp(input logic [7:0] glyph, input logic dp);
    return {glyph[7:1], glyph[0] & ~dp};
  endfunction

  // Refresh scan: one slot of REFRESH_DIV cycles per digit.
  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    wrap        = tick && (digit_idx_q == IDX_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end
  end

  // Pending/active buffers: the active copy only moves at a frame boundary,
  // and a load landing on that boundary bypasses the pending stage.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    act_lz_d     = act_lz_q;
    if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_en;
      pend_en_d    = digit_en;
      pend_lz_d    = lz_blank;
      pend_valid_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_value_d = value;
        act_dp_d    = dp_en;
        act_en_d    = digit_en;
        act_lz_d    = lz_blank;
      end else if (pend_valid_q) begin
        act_value_d = pend_value_q;
        act_dp_d    = pend_dp_q;
        act_en_d    = pend_en_q;
        act_lz_d    = pend_lz_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  // Leading-zero run scanned from the most significant digit down.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_value_q[4*i +: 4] == 4'h0);
      supp[i]  = act_lz_q && (i > 0) && zero_run;
    end
    lit = act_en_q & ~supp;
  end

  always_comb begin
    sel     = '0;
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        sel[i]  = 1'b1;
        cur_nib = act_value_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
        cur_lit = lit[i];
      end
    end
  end

  // The tick cycle is a dead cycle so the old and new digit never overlap.
  always_comb begin
    segments_d = 8'hFF;
    anodes_d   = '1;
    if (!tick && cur_lit) begin
      segments_d = apply_dp(hex_to_seg(cur_nib), cur_dp);
      anodes_d   = ~sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '1;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '1;
      act_lz_q     <= 1'b0;
      segments_q   <= 8'hFF;
      anodes_q     <= '1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= wrap;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      act_lz_q     <= act_lz_d;
      segments_q   <= segments_d;
      anodes_q     <= anodes_d;
    end
  end

  assign segments   = segments_q;
  assign anodes     = anodes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed bench for sevenseg_mux_driver at N_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
module tb_sevenseg_mux_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic        load;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0]  cap_an  [0:16];
  logic [7:0]  cap_seg [0:16];
  logic [16:0] cap_fdv;
  logic [7:0]  exp_seg [0:3];

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [31:0] segs;  // expected {d3,d2,d1,d0}, FF = blank
  } vec_t;

  vec_t tbl [0:6] = '{
    '{16'h12AF, 4'b0000, 4'b1111, 1'b0, 32'h9F251171},
    '{16'h0050, 4'b0100, 4'b1111, 1'b1, 32'hFFFF4903},
    '{16'h3456, 4'b0000, 4'b0101, 1'b0, 32'hFF99FF41},
    '{16'hBCDE, 4'b1010, 4'b1111, 1'b1, 32'hC0638461},
    '{16'h0000, 4'b0001, 4'b1111, 1'b1, 32'hFFFFFF02},
    '{16'h7089, 4'b0000, 4'b1111, 1'b1, 32'h1F030109},
    '{16'h0100, 4'b0000, 4'b1110, 1'b1, 32'hFF9F03FF}
  };

  sevenseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_en      (dp_en),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .load       (load),
    .segments   (segments),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(input int d, input logic [7:0] s);
    logic [3:0] m;
    m = 4'b0001 << d;
    return (s == 8'hFF) ? 4'hF : ~m;
  endfunction

  task automatic set_exp(input logic [31:0] s);
    for (int d = 0; d < 4; d++) exp_seg[d] = s[8*d +: 8];
  endtask

  task automatic load_data(input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] en, input logic lz);
    value = v; dp_en = dp; digit_en = en; lz_blank = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Records offsets 0..16 of the frame starting at the next frame_done; optionally
  // pulses load with new data at offset inj_off.
  task automatic capture_frame(input int inj_off, input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] en, input logic lz);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timeout: frame_done=%b required 1 within 40 cycles", frame_done);
    end
    for (int o = 0; o <= 16; o++) begin
      cap_an[o]  = anodes;
      cap_seg[o] = segments;
      cap_fdv[o] = frame_done;
      if (o == inj_off) begin
        value = v; dp_en = dp; digit_en = en; lz_blank = lz; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (o < 16) @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; load = 1'b0; value = 16'h0; dp_en = 4'h0; digit_en = 4'hF; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (anodes !== 4'hF || segments !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: anodes=%b segments=%h frame_done=%b required 1111 ff 0",
               anodes, segments, frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (anodes !== 4'b1110 || segments !== 8'h03) begin
      errors++;
      $display("FAIL reset_first_digit: anodes=%b segments=%h required 1110 03", anodes, segments);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL reset_first_frame_done: cycles=%0d required 15", n);
    end
  endtask

  task automatic test_patterns;
    for (int k = 0; k < 7; k++) begin
      load_data(tbl[k].v, tbl[k].dp, tbl[k].en, tbl[k].lz);
      capture_frame(-1, 16'h0, 4'h0, 4'hF, 1'b0);
      set_exp(tbl[k].segs);
      for (int o = 0; o < 16; o++) begin
        logic [3:0] ea;
        logic [7:0] es;
        if (o % 4 == 0) begin ea = 4'hF; es = 8'hFF; end
        else begin es = exp_seg[o/4]; ea = exp_an(o/4, es); end
        checks++;
        if (cap_an[o] !== ea || cap_seg[o] !== es) begin
          errors++;
          $display("FAIL pattern%0d offset %0d: anodes=%b segments=%h required %b %h",
                   k, o, cap_an[o], cap_seg[o], ea, es);
        end
      end
      checks++;
      if (cap_fdv !== 17'h10001) begin
        errors++;
        $display("FAIL pattern%0d frame_done: got %b required %b", k, cap_fdv, 17'h10001);
      end
    end
  endtask

  task automatic test_midframe_load;
    load_data(16'h12AF, 4'h0, 4'hF, 1'b0);
    capture_frame(-1, 16'h0, 4'h0, 4'hF, 1'b0);
    capture_frame(6, 16'h0000, 4'h0, 4'hF, 1'b0);
    for (int f = 0; f < 2; f++) begin
      set_exp((f == 0) ? 32'h9F251171 : 32'h03030303);
      for (int o = 0; o < 16; o++) begin
        logic [3:0] ea;
        logic [7:0] es;
        if (o % 4 == 0) begin ea = 4'hF; es = 8'hFF; end
        else begin es = exp_seg[o/4]; ea = exp_an(o/4, es); end
        checks++;
        if (cap_an[o] !== ea || cap_seg[o] !== es) begin
          errors++;
          $display("FAIL midframe frame%0d offset %0d: anodes=%b segments=%h required %b %h",
                   f, o, cap_an[o], cap_seg[o], ea, es);
        end
      end
      if (f == 0) capture_frame(-1, 16'h0, 4'h0, 4'hF, 1'b0);
    end
  endtask

  task automatic test_load_on_wrap;
    capture_frame(15, 16'h12AF, 4'h0, 4'hF, 1'b0);
    for (int f = 0; f < 2; f++) begin
      set_exp((f == 0) ? 32'h03030303 : 32'h9F251171);
      for (int o = 0; o < 16; o++) begin
        logic [3:0] ea;
        logic [7:0] es;
        if (o % 4 == 0) begin ea = 4'hF; es = 8'hFF; end
        else begin es = exp_seg[o/4]; ea = exp_an(o/4, es); end
        checks++;
        if (cap_an[o] !== ea || cap_seg[o] !== es) begin
          errors++;
          $display("FAIL load_on_wrap frame%0d offset %0d: anodes=%b segments=%h required %b %h",
                   f, o, cap_an[o], cap_seg[o], ea, es);
        end
      end
      if (f == 0) capture_frame(-1, 16'h0, 4'h0, 4'hF, 1'b0);
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (anodes !== 4'b1011 || segments !== 8'h25) begin
      errors++;
      $display("FAIL pre_reset_digit2: anodes=%b segments=%h required 1011 25", anodes, segments);
    end
    load_data(16'h8888, 4'hF, 4'hF, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (anodes !== 4'hF || segments !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: anodes=%b segments=%h frame_done=%b required 1111 ff 0",
               anodes, segments, frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (anodes !== 4'b1110 || segments !== 8'h03) begin
      errors++;
      $display("FAIL post_reset_digit0: anodes=%b segments=%h required 1110 03", anodes, segments);
    end
    capture_frame(-1, 16'h0, 4'h0, 4'hF, 1'b0);
    set_exp(32'h03030303);
    for (int o = 0; o < 16; o++) begin
      logic [3:0] ea;
      logic [7:0] es;
      if (o % 4 == 0) begin ea = 4'hF; es = 8'hFF; end
      else begin es = exp_seg[o/4]; ea = exp_an(o/4, es); end
      checks++;
      if (cap_an[o] !== ea || cap_seg[o] !== es) begin
        errors++;
        $display("FAIL post_reset_frame offset %0d: anodes=%b segments=%h required %b %h",
                 o, cap_an[o], cap_seg[o], ea, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_midframe_load();
    test_load_on_wrap();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
